// File: rtl/sbd_sqrt_chk.sv
// rtl/sbd_sqrt_chk.sv - sequential square-root result checker (Q*Q vs RAD)
//
// Squares a candidate root Q with a shift-add loop, then subtracts the square
// from the radicand RAD on the same adder. It flags whether Q is the integer
// square root of RAD, which holds when 0 <= RAD - Q*Q <= 2*Q.
//
// Ports:
//   CLK    in   rising-edge clock
//   RST_N  in   synchronous active-low reset
//   START  in   request, accepted in IDLE or DONE only
//   Q      in   [bitlength]    candidate root, captured on accept
//   RAD    in   [2*bitlength]  radicand, captured on accept
//   BUSY   out  high in every state except IDLE
//   DONE   out  one-cycle pulse, results valid
//   P      out  [2*bitlength]  Q*Q
//   R      out  [2*bitlength]  RAD - P modulo 2^(2*bitlength)
//   NEG    out  RAD < P
//   OK     out  ~NEG && R <= 2*Q
module sbd_sqrt_chk #(
    parameter int bitlength = 8
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     START,
    input  logic [bitlength-1:0]     Q,
    input  logic [2*bitlength-1:0]   RAD,
    output logic                     BUSY,
    output logic                     DONE,
    output logic [2*bitlength-1:0]   P,
    output logic [2*bitlength-1:0]   R,
    output logic                     NEG,
    output logic                     OK
);

    localparam int W  = 2 * bitlength;
    localparam int CW = $clog2(bitlength + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(bitlength - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_CHK  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [W-1:0]           mcand_q, mcand_d;
    logic [bitlength-1:0]   mult_q, mult_d;
    logic [bitlength-1:0]   q_cap_q, q_cap_d;
    logic [W-1:0]           rad_q, rad_d;
    logic [W-1:0]           acc_q, acc_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [W-1:0]           p_q, p_d;
    logic [W-1:0]           r_q, r_d;
    logic                   neg_q, neg_d;
    logic                   ok_q, ok_d;

    // Shared adder: accumulates partial products in MUL, computes
    // rad + ~acc + 1 in CHK. The carry out of the subtract is "no borrow".
    logic                   add_sub;
    logic [W-1:0]           add_a;
    logic [W-1:0]           add_b;
    logic [W:0]             add_sum;
    logic [W-1:0]           diff;
    logic                   carry;
    logic [W-1:0]           two_q;

    always_comb begin
        add_sub = (state_q == S_CHK);
        add_a   = add_sub ? rad_q : acc_q;
        add_b   = add_sub ? ~acc_q : (mult_q[0] ? mcand_q : '0);
        add_sum = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_sub};
        diff    = add_sum[W-1:0];
        carry   = add_sum[W];
        // 2*Q kept at full bitlength+1 precision so Q = max does not truncate.
        two_q   = {{(W-bitlength-1){1'b0}}, q_cap_q, 1'b0};
    end

    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        mult_d  = mult_q;
        q_cap_d = q_cap_q;
        rad_d   = rad_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        r_d     = r_q;
        neg_d   = neg_q;
        ok_d    = ok_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (START) begin
                    mcand_d = {{(W-bitlength){1'b0}}, Q};
                    mult_d  = Q;
                    q_cap_d = Q;
                    rad_d   = RAD;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_MUL;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL: begin
                acc_d   = diff;
                mcand_d = mcand_q << 1;
                mult_d  = mult_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = S_CHK;
                end
            end
            S_CHK: begin
                p_d     = acc_q;
                r_d     = diff;
                neg_d   = ~carry;
                ok_d    = carry && (diff <= two_q);
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            mcand_q <= '0;
            mult_q  <= '0;
            q_cap_q <= '0;
            rad_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
            r_q     <= '0;
            neg_q   <= 1'b0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            mult_q  <= mult_d;
            q_cap_q <= q_cap_d;
            rad_q   <= rad_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            r_q     <= r_d;
            neg_q   <= neg_d;
            ok_q    <= ok_d;
        end
    end

    assign BUSY = (state_q != S_IDLE);
    assign DONE = (state_q == S_DONE);
    assign P    = p_q;
    assign R    = r_q;
    assign NEG  = neg_q;
    assign OK   = ok_q;

endmodule

// File: tb/tb_sbd_sqrt_chk.sv
// tb/tb_sbd_sqrt_chk.sv - self-checking bench for sbd_sqrt_chk
module tb_sbd_sqrt_chk;

    logic        CLK;
    logic        RST_N;
    logic        START;
    logic [7:0]  Q;
    logic [15:0] RAD;
    logic        BUSY;
    logic        DONE;
    logic [15:0] P;
    logic [15:0] R;
    logic        NEG;
    logic        OK;

    sbd_sqrt_chk #(.bitlength(8)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .START (START),
        .Q     (Q),
        .RAD   (RAD),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .P     (P),
        .R     (R),
        .NEG   (NEG),
        .OK    (OK)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0]  q;
        logic [15:0] rad;
        logic [15:0] p;
        logic [15:0] r;
        logic        neg;
        logic        ok;
    } vec_t;

    vec_t vecs [11];
    vec_t exp_q [$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Scoreboard: every DONE pulse pops one expected result.
    always @(negedge CLK) begin
        if (DONE === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                vec_t e;
                e = exp_q.pop_front();
                chk("P",   32'(P),   32'(e.p));
                chk("R",   32'(R),   32'(e.r));
                chk("NEG", 32'(NEG), 32'(e.neg));
                chk("OK",  32'(OK),  32'(e.ok));
            end
        end
    end

    function automatic vec_t model(input logic [7:0] q, input logic [15:0] rad);
        vec_t v;
        int   sq;
        sq    = int'(q) * int'(q);
        v.q   = q;
        v.rad = rad;
        v.p   = 16'(sq);
        v.r   = 16'(int'(rad) - sq);
        v.neg = (int'(rad) < sq);
        v.ok  = !v.neg && ((int'(rad) - sq) <= 2 * int'(q));
        return v;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Issue one operation from IDLE and wait (bounded) for its DONE.
    task automatic run_op(input vec_t v);
        bit found;
        exp_q.push_back(v);
        START = 1'b1;
        Q     = v.q;
        RAD   = v.rad;
        step();
        START = 1'b0;
        Q     = 8'($urandom);
        RAD   = 16'($urandom);
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (DONE) found = 1;
            else step();
        end
        chk("done_timeout", 32'(found), 32'd1);
        step();
    endtask

    initial begin
        int   busy_cnt;
        int   done_idx;
        int   done_cnt;
        int   d1;
        int   d2;
        vec_t v;

        vecs[0]  = '{8'd0,   16'd0,     16'd0,     16'd0,      1'b0, 1'b1};
        vecs[1]  = '{8'd255, 16'd65535, 16'd65025, 16'd510,    1'b0, 1'b1};
        vecs[2]  = '{8'd15,  16'd256,   16'd225,   16'd31,     1'b0, 1'b0};
        vecs[3]  = '{8'd16,  16'd255,   16'd256,   16'hFFFF,   1'b1, 1'b0};
        vecs[4]  = '{8'd3,   16'd9,     16'd9,     16'd0,      1'b0, 1'b1};
        vecs[5]  = '{8'd4,   16'd20,    16'd16,    16'd4,      1'b0, 1'b1};
        vecs[6]  = '{8'd0,   16'd5,     16'd0,     16'd5,      1'b0, 1'b0};
        vecs[7]  = '{8'd100, 16'd10200, 16'd10000, 16'd200,    1'b0, 1'b1};
        vecs[8]  = '{8'd100, 16'd10201, 16'd10000, 16'd201,    1'b0, 1'b0};
        vecs[9]  = '{8'd1,   16'd0,     16'd1,     16'hFFFF,   1'b1, 1'b0};
        vecs[10] = '{8'd255, 16'd65024, 16'd65025, 16'hFFFF,   1'b1, 1'b0};

        RST_N = 1'b0;
        START = 1'b0;
        Q     = '0;
        RAD   = '0;
        step();
        step();
        RST_N = 1'b1;
        chk("rst_BUSY", 32'(BUSY), 32'd0);
        chk("rst_DONE", 32'(DONE), 32'd0);
        chk("rst_P",    32'(P),    32'd0);
        chk("rst_R",    32'(R),    32'd0);
        chk("rst_NEG",  32'(NEG),  32'd0);
        chk("rst_OK",   32'(OK),   32'd0);

        // Latency and BUSY width on the first op (Q=0, RAD=0).
        exp_q.push_back(vecs[0]);
        START = 1'b1;
        Q     = vecs[0].q;
        RAD   = vecs[0].rad;
        step();
        START = 1'b0;
        busy_cnt = 0;
        done_idx = -1;
        for (int i = 0; i < 14; i++) begin
            if (BUSY) busy_cnt++;
            if (DONE && done_idx < 0) done_idx = i;
            step();
        end
        chk("latency",    32'(done_idx), 32'd9);
        chk("busy_width", 32'(busy_cnt), 32'd10);

        for (int i = 1; i < 11; i++) run_op(vecs[i]);

        for (int i = 0; i < 6; i++) begin
            logic [7:0]  q;
            logic [15:0] rad;
            q   = 8'($urandom);
            rad = (i % 2 == 0) ? 16'(int'(q) * int'(q) + int'($urandom_range(0, 2 * int'(q) + 1)))
                               : 16'($urandom);
            run_op(model(q, rad));
        end

        // START pulses in MUL (cycles 3 and 7) are ignored.
        exp_q.push_back(vecs[2]);
        START = 1'b1;
        Q     = vecs[2].q;
        RAD   = vecs[2].rad;
        step();
        START = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            if (i == 2 || i == 6) begin
                START = 1'b1;
                Q     = 8'd200;
                RAD   = 16'd1;
            end else begin
                START = 1'b0;
            end
            if (DONE) done_cnt++;
            step();
        end
        START = 1'b0;
        chk("ignored_start_pulses", 32'(done_cnt), 32'd1);

        // START held high: back-to-back ops from the DONE state.
        exp_q.push_back(vecs[4]);
        exp_q.push_back(vecs[5]);
        START = 1'b1;
        Q     = vecs[4].q;
        RAD   = vecs[4].rad;
        step();
        Q     = vecs[5].q;
        RAD   = vecs[5].rad;
        d1 = -1;
        d2 = -1;
        for (int i = 0; i < 26; i++) begin
            if (i == 10) START = 1'b0;
            if (DONE) begin
                if (d1 < 0) d1 = i;
                else if (d2 < 0) d2 = i;
            end
            step();
        end
        chk("b2b_first_done", 32'(d1), 32'd9);
        chk("b2b_spacing",    32'(d2 - d1), 32'd10);

        // Reset mid-MUL discards the run.
        START = 1'b1;
        Q     = 8'd7;
        RAD   = 16'd49;
        step();
        START = 1'b0;
        step();
        step();
        RST_N = 1'b0;
        step();
        RST_N = 1'b1;
        chk("midrst_BUSY", 32'(BUSY), 32'd0);
        chk("midrst_P",    32'(P),    32'd0);
        chk("midrst_R",    32'(R),    32'd0);
        chk("midrst_NEG",  32'(NEG),  32'd0);
        chk("midrst_OK",   32'(OK),   32'd0);
        done_cnt = 0;
        for (int i = 0; i < 14; i++) begin
            if (DONE) done_cnt++;
            step();
        end
        chk("midrst_no_done", 32'(done_cnt), 32'd0);

        v = model(8'd7, 16'd49);
        run_op(v);

        step();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
